// File: rtl/xrf_pkg.sv
// Shared definitions for the XOR range register file: request op encoding and
// the per-entry range-membership test used to build the query mask.
package xrf_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_UPDATE = 2'b01;
  localparam logic [1:0] OP_QUERY  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  // Entry i belongs to the inclusive range [lo,hi]; an inverted range selects nothing.
  function automatic logic xrf_in_range(input logic [31:0] i,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (i >= lo) && (i <= hi);
  endfunction

endpackage

// File: rtl/xrf_cell.sv
// One WIDTH-bit XOR accumulator entry with synchronous clear and a gated
// read port so the parent can OR-free reduce all entries through an XOR tree.
module xrf_cell
  import xrf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] xor_in,
  input  logic             clr,
  input  logic             rd_en,
  output logic [WIDTH-1:0] q_masked
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (wr_en) begin
      r_q <= r_q ^ xor_in;
    end
  end

  assign q_masked = r_q & {WIDTH{rd_en}};

endmodule

// File: rtl/xor_range_regfile.sv
// DEPTH x WIDTH XOR register file with point updates and one-cycle [lo,hi]
// range-XOR queries. Define XRF_CLEAR_EN to make op 11 zero the whole array.
module xor_range_regfile
  import xrf_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_lo,
  input  logic [IDX_W-1:0] req_hi,
  input  logic [WIDTH-1:0] req_val,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  logic             w_accept;
  logic             w_do_update;
  logic             w_do_query;
  logic             w_do_clear;
  logic             w_range_err;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_q_masked [DEPTH];
  logic [DEPTH-1:0] w_rd_en;
  logic [DEPTH-1:0] w_wr_en;

  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  // A held response blocks every op, so updates can never overtake a pending result.
  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_do_update = 1'b0;
    w_do_query  = 1'b0;
    w_do_clear  = 1'b0;
    case (req_op)
      OP_NOP:    w_do_update = 1'b0;
      OP_UPDATE: w_do_update = w_accept;
      OP_QUERY:  w_do_query  = w_accept;
      OP_CLEAR: begin
`ifdef XRF_CLEAR_EN
        w_do_clear = w_accept;
`else
        w_do_clear = 1'b0;
`endif
      end
      default:   w_do_update = 1'b0;
    endcase
  end

  assign w_range_err = req_lo > req_hi;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    localparam logic [IDX_W-1:0] L_IDX = IDX_W'(gi);

    assign w_wr_en[gi] = w_do_update && (req_lo == L_IDX);
    assign w_rd_en[gi] = xrf_in_range(32'(gi), 32'(req_lo), 32'(req_hi));

    xrf_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (w_wr_en[gi]),
      .xor_in   (req_val),
      .clr      (w_do_clear),
      .rd_en    (w_rd_en[gi]),
      .q_masked (w_q_masked[gi])
    );
  end

  always_comb begin
    w_xor = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_xor = w_xor ^ w_q_masked[k];
    end
  end

  // Response register: a new query wins over a consume, so rsp_valid stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_do_query) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_range_err ? '0 : w_xor;
      r_rsp_err   <= w_range_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_xor_range_regfile.sv
// Bench for xor_range_regfile: directed scenarios plus random traffic, all
// compared against an array-based reference model of the register file.
module tb_xor_range_regfile;
  import xrf_pkg::*;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_lo;
  logic [3:0] req_hi;
  logic [7:0] req_val;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [16];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_err;

  xor_range_regfile #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_lo    (req_lo),
    .req_hi    (req_hi),
    .req_val   (req_val),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
  endtask

  function automatic logic [7:0] model_range(input int lo, input int hi);
    logic [7:0] x;
    x = 8'h00;
    for (int i = lo; i <= hi; i++) x = x ^ m_mem[i];
    return x;
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input int lo, input int hi,
                      input logic [7:0] val, input logic rr);
    logic rdy;
    logic acc;
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_lo    = lo[3:0];
    req_hi    = hi[3:0];
    req_val   = val;
    rsp_ready = rr;
    #1;
    rdy = !m_valid || rr;
    chk("req_ready", req_ready, rdy);
    @(posedge clk);
    acc = v && rdy;
    if (acc && op == OP_QUERY) begin
      m_valid = 1'b1;
      m_err   = lo > hi;
      m_data  = m_err ? 8'h00 : model_range(lo, hi);
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    if (acc && op == OP_UPDATE) m_mem[lo] = m_mem[lo] ^ val;
`ifdef XRF_CLEAR_EN
    if (acc && op == OP_CLEAR) model_zero();
`endif
    #1;
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_err", rsp_err, m_err);
    chk("rsp_data", rsp_data, m_data);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    model_zero();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_err   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int thru;
  logic [7:0] pre_clear;

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_op = OP_NOP; req_lo = '0; req_hi = '0; req_val = '0;
    rsp_ready = 1'b0;
    model_zero();
    m_valid = 1'b0; m_data = 8'h00; m_err = 1'b0;
    do_reset();

    // T1: reset while a response is pending, then a full-range query
    step(1, OP_QUERY, 0, 15, 8'h00, 0);
    do_reset();
    step(1, OP_QUERY, 0, 15, 8'h00, 1);
    chk("t1_after_rst", rsp_data, 8'h00);

    // T2: point updates then range queries
    step(1, OP_UPDATE, 3, 0, 8'hA5, 1);
    step(1, OP_UPDATE, 3, 0, 8'h0F, 1);
    step(1, OP_UPDATE, 9, 0, 8'h3C, 1);
    step(1, OP_QUERY, 3, 3, 8'h00, 1);
    chk("t2_q3_3", rsp_data, 8'hAA);
    step(1, OP_QUERY, 0, 15, 8'h00, 1);
    chk("t2_q0_15", rsp_data, 8'h96);
    step(1, OP_QUERY, 4, 8, 8'h00, 1);
    chk("t2_q4_8", rsp_data, 8'h00);

    // T3: inverted range
    step(1, OP_QUERY, 7, 2, 8'h00, 1);
    chk("t3_err", rsp_err, 1);
    chk("t3_data", rsp_data, 8'h00);
    step(1, OP_QUERY, 2, 7, 8'h00, 1);
    chk("t3_err_clr", rsp_err, 0);
    chk("t3_data2", rsp_data, 8'hAA);

    // T4: backpressure holds the response and stalls an update
    step(1, OP_QUERY, 3, 3, 8'h00, 0);
    step(1, OP_UPDATE, 3, 0, 8'h55, 0);
    chk("t4_hold", rsp_data, 8'hAA);
    chk("t4_stall_rdy", req_ready, 0);
    step(1, OP_UPDATE, 3, 0, 8'h55, 1);
    chk("t4_consumed", rsp_valid, 0);
    step(1, OP_QUERY, 3, 3, 8'h00, 1);
    chk("t4_landed", rsp_data, 8'hFF);

    // T5: update-then-query ordering and full throughput
    step(1, OP_UPDATE, 0, 0, 8'h01, 1);
    step(1, OP_QUERY, 0, 0, 8'h00, 1);
    chk("t5_order", rsp_data, 8'h01);
    step(0, OP_NOP, 0, 0, 8'h00, 1);
    thru = 0;
    for (int k = 0; k < 4; k++) begin
      step(1, OP_QUERY, k, 15, 8'h00, 1);
      if (rsp_valid) thru++;
    end
    chk("t5_thru", thru, 4);
    step(0, OP_NOP, 0, 0, 8'h00, 1);
    chk("t5_drain", rsp_valid, 0);

    // T6: clear (or NOP when the feature is absent)
    step(1, OP_UPDATE, 1, 0, 8'h11, 1);
    step(1, OP_UPDATE, 2, 0, 8'h22, 1);
    pre_clear = model_range(0, 15);
    step(1, OP_CLEAR, 0, 0, 8'h00, 1);
    step(1, OP_QUERY, 0, 15, 8'h00, 1);
`ifdef XRF_CLEAR_EN
    chk("t6_clear", rsp_data, 8'h00);
`else
    chk("t6_noclear", rsp_data, pre_clear);
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           8'($urandom), ($urandom_range(0, 9) < 7));
    end
    do_reset();
    step(1, OP_QUERY, 0, 15, 8'h00, 1);
    chk("final_zero", rsp_data, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
